// File: rtl/pool_window_feeder.sv
// Window sequencer for the FP16 average-pool unit: walks a row-major feature map,
// streams each KxK window serially into the pool unit and writes the pooled results.
module pool_window_feeder #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDR_WIDTH    = 12,
   parameter int unsigned DIM_WIDTH     = 8,
   parameter int unsigned K_WIDTH       = 3,
   parameter int unsigned CLK_NUM_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DIM_WIDTH-1:0]     fm_width,
   input  logic [DIM_WIDTH-1:0]     fm_height,
   input  logic [K_WIDTH-1:0]       pool_k,
   input  logic [K_WIDTH-1:0]       pool_stride,
   input  logic [ADDR_WIDTH-1:0]    fm_base_addr,
   input  logic [ADDR_WIDTH-1:0]    out_base_addr,
   output logic                     fm_rd_en,
   output logic [ADDR_WIDTH-1:0]    fm_rd_addr,
   input  logic [DATA_WIDTH-1:0]    fm_rd_data,
   output logic                     avg_rst_n,
   output logic [DATA_WIDTH-1:0]    avg_input_data,
   output logic [CLK_NUM_WIDTH-1:0] data_num,
   input  logic                     result_ready,
   input  logic [DATA_WIDTH-1:0]    avg_pool_result,
   output logic                     out_wr_en,
   output logic [ADDR_WIDTH-1:0]    out_wr_addr,
   output logic [DATA_WIDTH-1:0]    out_wr_data,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned EXT_WIDTH  = DIM_WIDTH + 1;
   localparam int unsigned PROD_WIDTH = EXT_WIDTH + DIM_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_STREAM,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t state, state_nxt;

   logic [DIM_WIDTH-1:0]     cfg_w, cfg_w_nxt, cfg_h, cfg_h_nxt;
   logic [DIM_WIDTH-1:0]     r0, r0_nxt, c0, c0_nxt;
   logic [K_WIDTH-1:0]       cfg_k, cfg_k_nxt, cfg_s, cfg_s_nxt;
   logic [K_WIDTH-1:0]       row, row_nxt, col, col_nxt;
   logic [ADDR_WIDTH-1:0]    fm_base, fm_base_nxt, out_base, out_base_nxt;
   logic [ADDR_WIDTH-1:0]    win_idx, win_idx_nxt;
   logic [CLK_NUM_WIDTH-1:0] rd_left, rd_left_nxt;
   logic                     last_win, last_win_nxt, rd_pend, rd_pend_nxt;

   logic                     fm_rd_en_nxt, avg_rst_n_nxt, out_wr_en_nxt, busy_nxt, done_nxt;
   logic [ADDR_WIDTH-1:0]    fm_rd_addr_nxt, out_wr_addr_nxt;
   logic [DATA_WIDTH-1:0]    avg_input_data_nxt, out_wr_data_nxt;
   logic [CLK_NUM_WIDTH-1:0] data_num_nxt;

   logic [CLK_NUM_WIDTH-1:0] k_sq;
   logic                     cfg_bad;
   logic [EXT_WIDTH-1:0]     row_sum, c0_step, r0_step;
   logic [PROD_WIDTH-1:0]    row_prod;
   logic [ADDR_WIDTH-1:0]    elem_addr;
   logic [K_WIDTH-1:0]       k_last, adv_row, adv_col;
   logic                     col_wrap, row_wrap, col_fits, row_fits;

   assign k_sq    = CLK_NUM_WIDTH'(pool_k) * CLK_NUM_WIDTH'(pool_k);
   assign cfg_bad = (pool_k == '0) || (DIM_WIDTH'(pool_k) > fm_width) ||
                    (DIM_WIDTH'(pool_k) > fm_height);

   // Address of the next element to read: base + (r0+row)*W + c0 + col, modulo the buffer size
   assign row_sum   = EXT_WIDTH'(r0) + EXT_WIDTH'(row);
   assign row_prod  = PROD_WIDTH'(row_sum) * PROD_WIDTH'(cfg_w);
   assign elem_addr = fm_base + ADDR_WIDTH'(row_prod) + ADDR_WIDTH'(c0) + ADDR_WIDTH'(col);

   // Row-major advance of the in-window element index; wraps to (0,0) after the last element
   assign k_last   = cfg_k - K_WIDTH'(1);
   assign col_wrap = (col == k_last);
   assign row_wrap = (row == k_last);
   assign adv_col  = col_wrap ? '0 : col + K_WIDTH'(1);
   assign adv_row  = !col_wrap ? row : (row_wrap ? '0 : row + K_WIDTH'(1));

   assign c0_step  = EXT_WIDTH'(c0) + EXT_WIDTH'(cfg_s);
   assign r0_step  = EXT_WIDTH'(r0) + EXT_WIDTH'(cfg_s);
   assign col_fits = (c0_step + EXT_WIDTH'(cfg_k)) <= EXT_WIDTH'(cfg_w);
   assign row_fits = (r0_step + EXT_WIDTH'(cfg_k)) <= EXT_WIDTH'(cfg_h);

   // Next-state and next-output logic
   always_comb begin
      state_nxt          = state;
      cfg_w_nxt          = cfg_w;
      cfg_h_nxt          = cfg_h;
      cfg_k_nxt          = cfg_k;
      cfg_s_nxt          = cfg_s;
      fm_base_nxt        = fm_base;
      out_base_nxt       = out_base;
      r0_nxt             = r0;
      c0_nxt             = c0;
      row_nxt            = row;
      col_nxt            = col;
      win_idx_nxt        = win_idx;
      rd_left_nxt        = rd_left;
      last_win_nxt       = last_win;
      rd_pend_nxt        = fm_rd_en;
      fm_rd_en_nxt       = 1'b0;
      fm_rd_addr_nxt     = fm_rd_addr;
      avg_rst_n_nxt      = avg_rst_n;
      avg_input_data_nxt = rd_pend ? fm_rd_data : '0;
      data_num_nxt       = data_num;
      out_wr_en_nxt      = 1'b0;
      out_wr_addr_nxt    = out_wr_addr;
      out_wr_data_nxt    = out_wr_data;
      busy_nxt           = busy;
      done_nxt           = 1'b0;

      // The pool unit leaves reset together with the first element it receives
      if (rd_pend) begin
         avg_rst_n_nxt = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (start) begin
               cfg_w_nxt    = fm_width;
               cfg_h_nxt    = fm_height;
               cfg_k_nxt    = pool_k;
               cfg_s_nxt    = (pool_stride == '0) ? K_WIDTH'(1) : pool_stride;
               fm_base_nxt  = fm_base_addr;
               out_base_nxt = out_base_addr;
               data_num_nxt = k_sq;
               r0_nxt       = '0;
               c0_nxt       = '0;
               win_idx_nxt  = '0;
               last_win_nxt = 1'b0;
               busy_nxt     = 1'b1;
               if (cfg_bad) begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
               end else begin
                  // Element (0,0) of window 0 sits at the base address itself
                  state_nxt      = ST_FETCH;
                  fm_rd_en_nxt   = 1'b1;
                  fm_rd_addr_nxt = fm_base_addr;
                  rd_left_nxt    = k_sq - CLK_NUM_WIDTH'(1);
                  row_nxt        = '0;
                  col_nxt        = (pool_k == K_WIDTH'(1)) ? '0 : K_WIDTH'(1);
               end
            end
         end

         ST_FETCH, ST_STREAM: begin
            if (rd_left != '0) begin
               state_nxt      = ST_STREAM;
               fm_rd_en_nxt   = 1'b1;
               fm_rd_addr_nxt = elem_addr;
               rd_left_nxt    = rd_left - CLK_NUM_WIDTH'(1);
               row_nxt        = adv_row;
               col_nxt        = adv_col;
            end else begin
               state_nxt = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (result_ready) begin
               state_nxt       = ST_WRITE;
               out_wr_en_nxt   = 1'b1;
               out_wr_data_nxt = avg_pool_result;
               out_wr_addr_nxt = out_base + win_idx;
               avg_rst_n_nxt   = 1'b0;
               win_idx_nxt     = win_idx + ADDR_WIDTH'(1);
               // Move the origin now so the next window's first read is ready after WRITE
               if (col_fits) begin
                  c0_nxt = DIM_WIDTH'(c0_step);
               end else if (row_fits) begin
                  c0_nxt = '0;
                  r0_nxt = DIM_WIDTH'(r0_step);
               end else begin
                  last_win_nxt = 1'b1;
               end
            end
         end

         ST_WRITE: begin
            if (last_win) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
            end else begin
               state_nxt      = ST_FETCH;
               fm_rd_en_nxt   = 1'b1;
               fm_rd_addr_nxt = elem_addr;
               rd_left_nxt    = data_num - CLK_NUM_WIDTH'(1);
               row_nxt        = adv_row;
               col_nxt        = adv_col;
            end
         end

         ST_DONE: begin
            state_nxt     = ST_IDLE;
            avg_rst_n_nxt = 1'b0;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, context and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         cfg_w          <= '0;
         cfg_h          <= '0;
         cfg_k          <= '0;
         cfg_s          <= '0;
         fm_base        <= '0;
         out_base       <= '0;
         r0             <= '0;
         c0             <= '0;
         row            <= '0;
         col            <= '0;
         win_idx        <= '0;
         rd_left        <= '0;
         last_win       <= 1'b0;
         rd_pend        <= 1'b0;
         fm_rd_en       <= 1'b0;
         fm_rd_addr     <= '0;
         avg_rst_n      <= 1'b0;
         avg_input_data <= '0;
         data_num       <= '0;
         out_wr_en      <= 1'b0;
         out_wr_addr    <= '0;
         out_wr_data    <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nxt;
         cfg_w          <= cfg_w_nxt;
         cfg_h          <= cfg_h_nxt;
         cfg_k          <= cfg_k_nxt;
         cfg_s          <= cfg_s_nxt;
         fm_base        <= fm_base_nxt;
         out_base       <= out_base_nxt;
         r0             <= r0_nxt;
         c0             <= c0_nxt;
         row            <= row_nxt;
         col            <= col_nxt;
         win_idx        <= win_idx_nxt;
         rd_left        <= rd_left_nxt;
         last_win       <= last_win_nxt;
         rd_pend        <= rd_pend_nxt;
         fm_rd_en       <= fm_rd_en_nxt;
         fm_rd_addr     <= fm_rd_addr_nxt;
         avg_rst_n      <= avg_rst_n_nxt;
         avg_input_data <= avg_input_data_nxt;
         data_num       <= data_num_nxt;
         out_wr_en      <= out_wr_en_nxt;
         out_wr_addr    <= out_wr_addr_nxt;
         out_wr_data    <= out_wr_data_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
      end
   end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: random feature maps, a buffer model, a pool-unit model
// and a window-walk reference that predicts every read address, write and its timing.
module tb_pool_window_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  fm_width, fm_height;
   logic [2:0]  pool_k, pool_stride;
   logic [11:0] fm_base_addr, out_base_addr;
   logic        fm_rd_en;
   logic [11:0] fm_rd_addr;
   logic [15:0] fm_rd_data;
   logic        avg_rst_n;
   logic [15:0] avg_input_data;
   logic [7:0]  data_num;
   logic        result_ready;
   logic [15:0] avg_pool_result;
   logic        out_wr_en;
   logic [11:0] out_wr_addr;
   logic [15:0] out_wr_data;
   logic        busy, done;

   pool_window_feeder dut (
      .clk(clk), .rst(rst), .start(start),
      .fm_width(fm_width), .fm_height(fm_height),
      .pool_k(pool_k), .pool_stride(pool_stride),
      .fm_base_addr(fm_base_addr), .out_base_addr(out_base_addr),
      .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
      .avg_rst_n(avg_rst_n), .avg_input_data(avg_input_data), .data_num(data_num),
      .result_ready(result_ready), .avg_pool_result(avg_pool_result),
      .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:4095];
   logic [11:0] exp_rd[$];
   logic [11:0] exp_wa[$];
   logic [15:0] exp_wd[$];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int start_cyc = 0, xn = 0, xd = 0, widx = 0, n_rd = 0, n_wr = 0;
   bit noise_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference window walk; the pooled value is an order-sensitive weighted sum
   function automatic int build_exp(input int w, input int h, input int k, input int s,
                                    input int fb, input int ob);
      int st, nw, sum;
      logic [11:0] a;
      st = (s == 0) ? 1 : s;
      nw = 0;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      if (k == 0 || k > w || k > h) return 0;
      for (int r0 = 0; r0 + k <= h; r0 += st)
         for (int c0 = 0; c0 + k <= w; c0 += st) begin
            sum = 0;
            for (int i = 0; i < k; i++)
               for (int j = 0; j < k; j++) begin
                  a = 12'(fb + (r0 + i) * w + c0 + j);
                  exp_rd.push_back(a);
                  sum += int'(mem[a]) * (i * k + j + 1);
               end
            exp_wa.push_back(12'(ob + nw));
            exp_wd.push_back(16'(sum));
            nw++;
         end
      return nw;
   endfunction

   // Feature-map buffer: data valid the cycle after the strobe, junk otherwise
   initial begin
      bit pend = 1'b0;
      logic [11:0] paddr = '0;
      fm_rd_data = '0;
      forever begin
         @(negedge clk);
         fm_rd_data = pend ? mem[paddr] : 16'($urandom);
         pend  = fm_rd_en;
         paddr = fm_rd_addr;
      end
   end

   // Pool unit: takes data_num elements, answers 3 (+xd) cycles after the last one
   initial begin
      int pcnt = 0, acc = 0, wt = 0;
      result_ready = 1'b0;
      avg_pool_result = '0;
      forever begin
         @(negedge clk);
         result_ready = 1'b0;
         if (!avg_rst_n) begin
            pcnt = 0; acc = 0; wt = 0;
            if (noise_en && fm_rd_en && $urandom_range(0, 1) == 1) begin
               result_ready = 1'b1;
               avg_pool_result = 16'($urandom);
            end
         end else if (pcnt < int'(data_num)) begin
            acc += int'(avg_input_data) * (pcnt + 1);
            pcnt++;
         end else begin
            wt++;
            if (wt == 1) check_eq("in_zero", 32'(avg_input_data), 0);
            if (wt == 3 + xd) begin
               result_ready = 1'b1;
               avg_pool_result = 16'(acc);
            end
         end
      end
   end

   // Read/write monitor against the reference queues
   initial begin
      forever begin
         @(negedge clk);
         if (rst && fm_rd_en) begin
            n_rd++;
            if (exp_rd.size() == 0) check_eq("rd_extra", 1, 0);
            else check_eq("rd_addr", 32'(fm_rd_addr), 32'(exp_rd.pop_front()));
         end
         if (rst && out_wr_en) begin
            n_wr++;
            if (exp_wa.size() == 0) check_eq("wr_extra", 1, 0);
            else begin
               check_eq("wr_addr", 32'(out_wr_addr), 32'(exp_wa.pop_front()));
               check_eq("wr_data", 32'(out_wr_data), 32'(exp_wd.pop_front()));
               check_eq("wr_cyc", 32'(cyc), 32'(start_cyc + (widx + 1) * (xn + 6 + xd)));
            end
            widx++;
         end
      end
   end

   task automatic launch(input int w, input int h, input int k, input int s,
                         input int fb, input int ob, input int d);
      xn = k * k; xd = d; widx = 0; n_rd = 0; n_wr = 0;
      fm_width = 8'(w); fm_height = 8'(h); pool_k = 3'(k); pool_stride = 3'(s);
      fm_base_addr = 12'(fb); out_base_addr = 12'(ob);
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      fm_width = 8'($urandom); fm_height = 8'($urandom);
      pool_k = 3'($urandom); pool_stride = 3'($urandom);
      fm_base_addr = 12'($urandom); out_base_addr = 12'($urandom);
   endtask

   task automatic run(input int w, input int h, input int k, input int s,
                      input int fb, input int ob, input int d, input bit poke);
      int nwin, t;
      bit bad;
      bad  = (k == 0) || (k > w) || (k > h);
      nwin = build_exp(w, h, k, s, fb, ob);
      launch(w, h, k, s, fb, ob, d);
      check_eq("data_num", 32'(data_num), 32'(k * k));
      check_eq("busy_start", 32'(busy), 32'(!bad));
      check_eq("done_start", 32'(done), 32'(bad));
      if (poke && !bad) begin
         repeat (2) @(negedge clk);
         fm_width = 8'(1); fm_height = 8'(1); pool_k = 3'(1);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while (!done && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check_eq("done_seen", 32'(done), 1);
      check_eq("done_cyc", 32'(cyc), bad ? 32'(start_cyc + 1) : 32'(start_cyc + nwin * (xn + 6 + d) + 1));
      check_eq("n_wr", 32'(n_wr), 32'(nwin));
      check_eq("n_rd", 32'(n_rd), 32'(nwin * xn));
      @(negedge clk);
      check_eq("done_pulse", 32'({done, busy}), 0);
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_ctl"}, 32'({fm_rd_en, out_wr_en, avg_rst_n, busy, done}), 0);
      check_eq({tag, "_dat"}, 32'({avg_input_data, out_wr_data}), 0);
      check_eq({tag, "_adr"}, 32'({fm_rd_addr, out_wr_addr, data_num}), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      rst = 1'b0; start = 1'b0;
      fm_width = '0; fm_height = '0; pool_k = '0; pool_stride = '0;
      fm_base_addr = '0; out_base_addr = '0;
      for (int a = 0; a < 4096; a++) mem[a] = 16'h3C00;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b1;
      @(negedge clk);

      run(4, 4, 2, 2, 12'h100, 12'h800, 0, 1'b0);
      for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
      for (int a = 0; a < 16; a++) mem[12'h200 + a] = 16'(a + 1);
      run(4, 4, 2, 2, 12'h200, 12'h010, 0, 1'b0);
      run(5, 3, 3, 1, 12'hFFA, 12'hFFE, 0, 1'b0);
      run(3, 5, 4, 1, 12'h000, 12'h000, 0, 1'b0);
      run(4, 4, 0, 1, 12'h000, 12'h000, 0, 1'b0);

      noise_en = 1'b1;
      run(4, 3, 2, 0, 12'h345, 12'h100, 0, 1'b0);
      run(3, 2, 1, 1, 12'h7F0, 12'h200, 0, 1'b0);
      run(6, 5, 3, 2, 12'hABC, 12'h300, 5, 1'b1);
      for (int n = 0; n < 6; n++)
         run($urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(0, 5),
             $urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(0, 4095),
             $urandom_range(0, 3), 1'b1);

      // Abort mid-window, then a fresh start must begin again at window 0
      void'(build_exp(6, 6, 3, 1, 12'h050, 12'h400));
      launch(6, 6, 3, 1, 12'h050, 12'h400, 0);
      t = 0;
      while (!fm_rd_en && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check_eq("abort_busy", 32'(busy), 1);
      rst = 1'b0;
      #1;
      check_quiet("abort");
      @(negedge clk);
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      rst = 1'b1;
      @(negedge clk);
      run(6, 6, 3, 1, 12'h050, 12'h400, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
